// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl
// Run controller and result monitor placed around the RV32I pipeline core in
// system-level benches. It sequences the core reset and counts run and retire
// cycles. It ends the run on a halt request or when the cycle budget runs out.
// Each monitored channel is compressed into a MISR signature, so a run can be
// checked against one golden value per channel.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous, active-low reset
//   start        - begin a run (accepted in IDLE/DONE only)
//   halt_req     - core halt indication (accepted in RUN only)
//   mon_valid    - mon_bus carries a retired result this cycle
//   mon_bus      - NUM_CH packed channels, channel k at [k*XLEN +: XLEN]
//   core_reset   - active-high reset to the core, registered
//   running      - high in RUN and DRAIN
//   done         - high in DONE
//   timeout      - high in DONE when the run ended on the cycle budget
//   cycle_count  - cycles spent in RUN+DRAIN (saturating)
//   retire_count - mon_valid pulses accepted in RUN+DRAIN (saturating)
//   signature    - per-channel MISR values, same packing as mon_bus
module sim_run_ctrl #(
    parameter int              XLEN         = 32,
    parameter int              NUM_CH       = 2,
    parameter int              CNT_W        = 16,
    parameter int              RST_CYCLES   = 2,
    parameter int              MAX_CYCLES   = 64,
    parameter int              DRAIN_CYCLES = 4,
    parameter logic [31:0]     POLY         = 32'h04C11DB7,
    parameter logic [XLEN-1:0] SEED         = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     halt_req,
    input  logic                     mon_valid,
    input  logic [NUM_CH*XLEN-1:0]   mon_bus,
    output logic                     core_reset,
    output logic                     running,
    output logic                     done,
    output logic                     timeout,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         retire_count,
    output logic [NUM_CH*XLEN-1:0]   signature
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // One phase counter serves both RST and DRAIN; it restarts on every
    // state change, so it is sized for the longer of the two phases.
    localparam int PMAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int PW   = $clog2(PMAX + 2);

    localparam logic [PW-1:0]    RST_LAST    = PW'(RST_CYCLES - 1);
    localparam logic [PW-1:0]    DRAIN_LAST  = PW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [XLEN-1:0]  POLY_X      = XLEN'(POLY);

    state_t                  state;
    state_t                  state_nxt;
    logic [PW-1:0]           phase_cnt;
    logic                    budget_hit;
    logic                    monitor;
    logic                    launch;
    logic [NUM_CH*XLEN-1:0]  sig_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [XLEN-1:0] misr_step(input logic [XLEN-1:0] sig,
                                                  input logic [XLEN-1:0] data);
        return ((sig << 1) ^ (sig[XLEN-1] ? POLY_X : '0)) ^ data;
    endfunction

    // ---- state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state decode ----
    always_comb begin
        state_nxt  = state;
        budget_hit = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_RST;
            end
            S_RST: begin
                if (phase_cnt == RST_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                // halt wins over the budget when both land on the same cycle
                if (halt_req) begin
                    state_nxt = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end else if (cycle_count == BUDGET_LAST) begin
                    state_nxt  = S_DONE;
                    budget_hit = 1'b1;
                end
            end
            S_DRAIN: begin
                if (phase_cnt == DRAIN_LAST) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign monitor = (state == S_RUN) || (state == S_DRAIN);
    assign launch  = start && ((state == S_IDLE) || (state == S_DONE));

    // ---- MISR update per channel ----
    always_comb begin
        sig_nxt = signature;
        for (int k = 0; k < NUM_CH; k++) begin
            sig_nxt[k*XLEN +: XLEN] = misr_step(signature[k*XLEN +: XLEN],
                                                mon_bus[k*XLEN +: XLEN]);
        end
    end

    // ---- registered outputs, counters and signatures ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_cnt    <= '0;
            core_reset   <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
            retire_count <= '0;
            signature    <= {NUM_CH{SEED}};
        end else begin
            if (state_nxt != state) begin
                phase_cnt <= '0;
            end else if ((state == S_RST) || (state == S_DRAIN)) begin
                phase_cnt <= phase_cnt + 1'b1;
            end

            // Outputs follow the state being entered so they line up with it.
            core_reset <= !((state_nxt == S_RUN) || (state_nxt == S_DRAIN));
            running    <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            done       <= (state_nxt == S_DONE);

            if (launch) begin
                timeout      <= 1'b0;
                cycle_count  <= '0;
                retire_count <= '0;
                signature    <= {NUM_CH{SEED}};
            end else begin
                if (monitor) begin
                    cycle_count <= sat_inc(cycle_count);
                end
                if (monitor && mon_valid) begin
                    retire_count <= sat_inc(retire_count);
                    signature    <= sig_nxt;
                end
                if (budget_hit) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule
